ps_bram_frame_writer: RTL
=========================

// Module: ps_bram_frame_writer
// PURPOSE
//  Producer end of the PS-BRAM pixel interface: accepts packed 64-bit pixel words from the PS,
//  splits them into R/G/B 16-bit channels and writes them to the three channel BRAMs.
//  It fills addresses 0..MAX-1 sequentially.
//  PS_BRAM_busy stays high during the fill and falls when the frame is complete, which releases the Top reader.
// PARAMETERS
//  PS_BRAM_DATAWIDTH  64    packed word width; R=[47:32], G=[31:16], B=[15:0], [63:48] reserved (must be 0)
//  CH_WIDTH           16    per-channel pixel width
//  BRAM_ADDR_WIDTH    13    channel BRAM address width (8192 locations)
//  MAX                7056  pixels per frame (84x84); addresses >= MAX never written
// PORTS
//  clk_fast       in   1   single clock; all logic on posedge
//  reset          in   1   asynchronous, active-low reset
//  frame_start    in   1   one-cycle pulse: begin filling a new frame (honoured only in IDLE)
//  s_valid        in   1   PS word valid
//  s_data         in   64  packed pixel word
//  s_ready        out  1   writer can accept s_data this cycle
//  wr_en          out  1   channel BRAM write strobe (drives wea/ena of R/G/B BRAMs)
//  wr_addr        out  13  BRAM write address
//  wr_r/wr_g/wr_b out  16  channel write data
//  PS_BRAM_busy   out  1   high from frame_start acceptance until the last pixel is written
//  frame_done     out  1   one-cycle pulse, cycle after last write
//  fmt_err        out  1   sticky: a reserved field [63:48] != 0 was accepted; cleared by frame_start
// BEHAVIOUR
//  Reset: state=IDLE; s_ready=0, wr_en=0, wr_addr=0, wr_r/g/b=0, PS_BRAM_busy=0, frame_done=0,
//   fmt_err=0, pixel counter=0.
//  Transfer: a word is accepted on the cycle where s_valid && s_ready.
//  s_valid without s_ready holds the word and is not accepted.
//  Write latency: accept at cycle N -> wr_en=1 at N+1 with wr_addr = count and channels from that word.
//   wr_en=0 on every cycle not following an accept. Outputs are registered; wr_r/g/b hold their last value when idle.
//  FSM:
//   IDLE : s_ready=0, busy=0. frame_start -> FILL; count<=0, fmt_err<=0, busy<=1 the next cycle.
//   FILL : s_ready=1. Each accept increments count.
//          Accept with count==MAX-1 -> LAST, s_ready<=0.
//          frame_start in FILL is ignored (no restart, no count change).
//   LAST : final write issued (wr_en=1, wr_addr=MAX-1). Go to DONE.
//   DONE : frame_done=1 and busy<=0 this cycle. Go to IDLE.
//  PS_BRAM_busy falls on the same edge that raises frame_done.
//  Count arithmetic: count is BRAM_ADDR_WIDTH bits; it never wraps past MAX-1, so wr_addr <= MAX-1 always.
//  Words offered in IDLE/LAST/DONE are not accepted (s_ready=0); PS must re-offer them in the next frame.
//  frame_start coinciding with the DONE cycle is ignored. frame_start on the first IDLE cycle is honoured.
//  Reset mid-frame: every output returns to its reset value asynchronously. The partial frame is abandoned.
//   No frame_done is generated. BRAM contents are undefined until a full refill.
// CONFIGURATION
//  FRAME_CHECKSUM_EN defined: adds output frame_checksum[15:0].
//   It is the mod-2^16 sum of R+G+B over all accepted pixels, cleared at frame_start.
//   It is valid and stable from the frame_done cycle until the next frame_start.
//   Reset value is 0.
//  FRAME_CHECKSUM_EN undefined: no port and no adder logic. All other behaviour is identical.
// TESTING
//  1 Reset then frame_start, with 7056 back-to-back words where R=addr, G=addr+1, B=addr+2:
//    -> 7056 wr_en pulses, wr_addr 0..7055, and frame_done exactly one cycle after the wr_addr=7055 write.
//    -> busy is 1 throughout the fill and 0 with frame_done.
//  2 s_valid toggled 1/0 every cycle during the fill:
//    -> wr_en only on cycles after an accept, no address skipped or repeated, frame_done after 7056 accepts.
//  3 frame_start pulsed again at count=100, and s_valid held high in DONE/IDLE:
//    -> count is unchanged and fill continues.
//    -> no accept occurs after count 7055 until the next frame_start.
//  4 reset asserted low at count=3000, released, then a new frame is filled:
//    -> outputs are 0 immediately and there is no frame_done.
//    -> the new frame starts at wr_addr 0 and completes normally.
//  5 one word with s_data[63:48]=16'h0001 at addr 10:
//    -> fmt_err=1 from the next cycle, still written to addr 10, and cleared by the next frame_start.
//  6 FRAME_CHECKSUM_EN with all words R=1, G=2, B=3:
//    -> frame_checksum = (7056*6) mod 65536 = 16'hA560 at frame_done.

Source files
------------

// File: rtl/ps_bram_frame_writer.sv
// PS-to-BRAM frame writer: unpacks 64-bit PS words into R/G/B channels and fills addresses 0..MAX-1.
// Optional FRAME_CHECKSUM_EN adds frame_checksum, the mod-2^16 sum of R+G+B over the frame.
module ps_bram_frame_writer #(
  parameter int PS_BRAM_DATAWIDTH = 64,
  parameter int CH_WIDTH          = 16,
  parameter int BRAM_ADDR_WIDTH   = 13,
  parameter int MAX               = 7056
) (
  input  logic                         clk_fast,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         s_valid,
  input  logic [PS_BRAM_DATAWIDTH-1:0] s_data,
  output logic                         s_ready,
  output logic                         wr_en,
  output logic [BRAM_ADDR_WIDTH-1:0]   wr_addr,
  output logic [CH_WIDTH-1:0]          wr_r,
  output logic [CH_WIDTH-1:0]          wr_g,
  output logic [CH_WIDTH-1:0]          wr_b,
  output logic                         PS_BRAM_busy,
  output logic                         frame_done,
  output logic                         fmt_err,
`ifdef FRAME_CHECKSUM_EN
  output logic [15:0]                  frame_checksum,
`endif
  output logic [1:0]                   dbg_state
);

  // Handshake: a word transfers on any rising edge where s_valid && s_ready are both high;
  // s_ready is registered and only high in FILL, so the PS must hold s_data until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, LAST = 2'd2, DONE = 2'd3} state_t;

  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = BRAM_ADDR_WIDTH'(MAX - 1);
  localparam int RSV_W = PS_BRAM_DATAWIDTH - 3 * CH_WIDTH;

  state_t                       state_q;
  logic [BRAM_ADDR_WIDTH-1:0]   count_q, count_d;
  logic                         s_ready_q, wr_en_q, busy_q, frame_done_q, fmt_err_q;
  logic [BRAM_ADDR_WIDTH-1:0]   wr_addr_q;
  logic [CH_WIDTH-1:0]          wr_r_q, wr_g_q, wr_b_q;
  logic                         accept;
  logic [CH_WIDTH-1:0]          px_r, px_g, px_b;
  logic [RSV_W-1:0]             px_rsv;

  always_comb begin
    accept  = s_valid && s_ready_q;
    count_d = count_q + 1'b1;
    px_r    = s_data[2*CH_WIDTH +: CH_WIDTH];
    px_g    = s_data[CH_WIDTH +: CH_WIDTH];
    px_b    = s_data[0 +: CH_WIDTH];
    px_rsv  = s_data[PS_BRAM_DATAWIDTH-1 : 3*CH_WIDTH];
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      s_ready_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_r_q       <= '0;
      wr_g_q       <= '0;
      wr_b_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      fmt_err_q    <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= count_q;
        wr_r_q    <= px_r;
        wr_g_q    <= px_g;
        wr_b_q    <= px_b;
        if (px_rsv != '0) fmt_err_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (frame_start) begin
          state_q   <= FILL;
          count_q   <= '0;
          fmt_err_q <= 1'b0;
          busy_q    <= 1'b1;
          s_ready_q <= 1'b1;
        end
        FILL: if (accept) begin
          // Count parks at MAX-1 so wr_addr can never pass the frame end.
          if (count_q == LAST_ADDR) begin
            state_q   <= LAST;
            s_ready_q <= 1'b0;
          end else begin
            count_q <= count_d;
          end
        end
        LAST: begin
          state_q      <= DONE;
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] cks_q;

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      cks_q <= '0;
    end else if (state_q == IDLE && frame_start) begin
      cks_q <= '0;
    end else if (accept) begin
      cks_q <= cks_q + 16'(px_r) + 16'(px_g) + 16'(px_b);
    end
  end

  assign frame_checksum = cks_q;
`endif

  assign s_ready      = s_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_r         = wr_r_q;
  assign wr_g         = wr_g_q;
  assign wr_b         = wr_b_q;
  assign PS_BRAM_busy = busy_q;
  assign frame_done   = frame_done_q;
  assign fmt_err      = fmt_err_q;
  assign dbg_state    = state_q;

endmodule
